// File: rtl/invert.sv
// Serial LSB-first two's-complementer: bits pass through up to and including the first 1,
// every later bit is inverted. Define INVERT_WORD_FRAME_EN to restart every WORD_W bits.
module invert #(
    parameter int unsigned WORD_W = 8
) (
    input  logic i,
    input  logic r,
    input  logic t_clk,
    output logic y
);

    typedef enum logic {
        StPass,
        StInv
    } state_e;

    state_e state_q;

    // Mealy output; forced low while reset is asserted.
    always_comb begin
        y = 1'b0;
        if (r) begin
            y = (state_q == StInv) ? ~i : i;
        end
    end

`ifdef INVERT_WORD_FRAME_EN
    localparam int unsigned CntW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);

    logic [CntW-1:0] cnt_q;

    // The completing edge of a word always returns to PASS, even when i=1 on that edge.
    always_ff @(posedge t_clk) begin
        if (!r) begin
            state_q <= StPass;
            cnt_q   <= '0;
        end else if (cnt_q == LastBit) begin
            state_q <= StPass;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (i) begin
                state_q <= StInv;
            end
        end
    end
`else
    always_ff @(posedge t_clk) begin
        if (!r) begin
            state_q <= StPass;
        end else if (i) begin
            state_q <= StInv;
        end
    end
`endif

endmodule

// File: tb/tb_invert.sv
// Self-checking bench for invert: directed vector table plus randomized stimulus against an
// arithmetic model (each output bit is bit k of the negated word prefix).
module tb_invert;

`ifdef INVERT_WORD_FRAME_EN
    localparam bit Framed = 1'b1;
`else
    localparam bit Framed = 1'b0;
`endif

    logic t_clk;
    logic r;
    logic i;
    logic y8;
    logic y4;

    int n_checks;
    int n_fail;

    invert #(.WORD_W(8)) dut8 (
        .i    (i),
        .r    (r),
        .t_clk(t_clk),
        .y    (y8)
    );

    invert #(.WORD_W(4)) dut4 (
        .i    (i),
        .r    (r),
        .t_clk(t_clk),
        .y    (y4)
    );

    initial begin
        t_clk = 1'b0;
        forever #5 t_clk = ~t_clk;
    end

    typedef struct {
        logic r;
        logic i;
        logic y8;
        logic y4;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic addv(input logic rv, input logic iv, input logic e8, input logic e4);
        vq.push_back('{r: rv, i: iv, y8: e8, y4: e4});
    endtask

    // One reset edge, then n bits taken LSB-first from the given words.
    task automatic add_seq(input logic [15:0] ib, input logic [15:0] yb8,
                           input logic [15:0] yb4f, input logic [15:0] yb4n, input int n);
        logic [15:0] yb4;
        yb4 = Framed ? yb4f : yb4n;
        addv(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            addv(1'b1, ib[k], yb8[k], yb4[k]);
        end
    endtask

    // Reference model: per-DUT word prefix value and bit position.
    longint unsigned p[2];
    int              kpos[2];
    int              wid[2];

    function automatic logic model_y(input int d, input logic rv, input logic iv);
        longint unsigned pp;
        longint unsigned neg;
        if (!rv) return 1'b0;
        pp  = p[d] | (longint'(iv) << kpos[d]);
        neg = (~pp) + 64'd1;
        return neg[kpos[d]];
    endfunction

    function automatic void model_step(input int d, input logic rv, input logic iv);
        if (!rv) begin
            p[d]    = 0;
            kpos[d] = 0;
        end else begin
            p[d]    = p[d] | (longint'(iv) << kpos[d]);
            kpos[d] = kpos[d] + 1;
            if (Framed && kpos[d] == wid[d]) begin
                p[d]    = 0;
                kpos[d] = 0;
            end
        end
    endfunction

    initial begin
        logic rr;
        logic ii;
        logic e8;
        logic e4;

        n_checks = 0;
        n_fail   = 0;
        r        = 1'b0;
        i        = 1'b0;
        wid[0]   = 8;
        wid[1]   = 4;

        // LSB-first conversion 0x68 -> 0x98
        add_seq(16'h0068, 16'h0098, 16'h00A8, 16'h0098, 8);
        // all-zero word, then a 1 still passes unchanged
        add_seq(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8);
        addv(1'b1, 1'b1, 1'b1, 1'b1);
        // reset mid-operation; y stays 0 while r=0 even with i=1
        add_seq(16'h0001, 16'h0003, 16'h0003, 16'h0003, 2);
        addv(1'b0, 1'b1, 1'b0, 1'b0);
        addv(1'b1, 1'b0, 1'b0, 1'b0);
        addv(1'b1, 1'b1, 1'b1, 1'b1);
        addv(1'b1, 1'b1, 1'b0, 1'b0);
        // simultaneous reset and 1
        addv(1'b0, 1'b1, 1'b0, 1'b0);
        addv(1'b1, 1'b0, 1'b0, 1'b0);
        addv(1'b1, 1'b1, 1'b1, 1'b1);
        // alternating pattern
        add_seq(16'h0005, 16'h000B, 16'h000B, 16'h000B, 4);
        // framing boundary, 1 arriving on the completing edge of a 4-bit word
        add_seq(16'h002F, 16'h00D1, 16'h00E1, 16'h00D1, 8);
        add_seq(16'h0048, 16'h00B8, 16'h00C8, 16'h00B8, 8);

        @(posedge t_clk);
        #1;
        foreach (vq[n]) begin
            r = vq[n].r;
            i = vq[n].i;
            #1;
            check($sformatf("vec[%0d] y(W=8)", n), y8, vq[n].y8);
            check($sformatf("vec[%0d] y(W=4)", n), y4, vq[n].y4);
            @(posedge t_clk);
            #1;
        end

        // Randomized phase from a fresh reset.
        r = 1'b0;
        i = 1'b0;
        @(posedge t_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            p[d]    = 0;
            kpos[d] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            rr = ($urandom_range(15) != 0);
            if (kpos[0] >= 56 || kpos[1] >= 56) rr = 1'b0;
            ii = 1'($urandom_range(1));
            r  = rr;
            i  = ii;
            e8 = model_y(0, rr, ii);
            e4 = model_y(1, rr, ii);
            #1;
            check($sformatf("rand[%0d] y(W=8)", c), y8, e8);
            check($sformatf("rand[%0d] y(W=4)", c), y4, e4);
            @(posedge t_clk);
            #1;
            model_step(0, rr, ii);
            model_step(1, rr, ii);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/invert.md
INVERT -- requirements
Module: invert

Interface
REQ-001 Parameter: WORD_W, default 8, serial word length in bits used by the framing feature (legal range 2..32).
REQ-002 Port: t_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: r  input  1  reset, synchronous, active-low (sampled on rising edge of t_clk).
REQ-004 Port: i  input  1  serial data in, LSB first, one bit per t_clk cycle.
REQ-005 Port: y  output  1  serial two's-complement data out, same bit slot as i.
REQ-006 Positional port order SHALL be (i, r, t_clk, y).

Function
REQ-007 Block SHALL be a serial two's-complementer: copy input bits up to and including the first 1, then invert every later bit.
REQ-008 FSM SHALL have two states: PASS (no 1 seen yet in current word) and INV (a 1 already seen).
REQ-009 In PASS, y SHALL equal i combinationally (Mealy, zero-cycle latency).
REQ-010 In INV, y SHALL equal ~i combinationally.
REQ-011 Transition PASS->INV SHALL occur at the rising edge where r=1 and i=1; the bit at that edge is passed unchanged.
REQ-012 PASS with i=0 SHALL stay in PASS; INV SHALL stay in INV regardless of i, except as in REQ-013/REQ-019.
REQ-013 Any rising edge with r=0 SHALL force state PASS and clear the bit counter, regardless of i or state; reset wins over every other event.
REQ-014 While r=0, y SHALL be driven 0 combinationally, independent of i and state.
REQ-015 Input X/Z on i SHALL NOT be required to produce a defined y; state before the first reset edge is undefined.
REQ-016 All-zero words SHALL produce all-zero output (two's complement of 0 is 0); FSM stays in PASS.

Reset
REQ-017 Reset value: state=PASS, bit counter=0; with r held 0, y=0.
REQ-018 Deasserting r (1 at a rising edge) SHALL start processing at the bit presented in that same cycle; no extra idle cycle is required.

Configuration
REQ-019 Macro INVERT_WORD_FRAME_EN defined: a counter SHALL count processed bits (edges with r=1). At the edge completing bit WORD_W of a word, the counter SHALL wrap to 0 and the state SHALL return to PASS. The next bit is then treated as the LSB of a new word, even if a 1 arrives on that completing edge.
REQ-020 Macro INVERT_WORD_FRAME_EN undefined: no counter logic; state leaves INV only on reset; WORD_W is ignored.
REQ-021 The two builds SHALL behave identically within the first WORD_W bits after reset.

Verification
REQ-022 Check the LSB-first conversion: r=0 for one edge, then r=1 with i = 0,0,0,1,0,1,1,0 -> y = 0,0,0,1,1,0,0,1 (0x68 -> 0x98).
REQ-023 Check the all-zero word: after reset, 8 bits of i=0 -> y=0 on all 8 bits, state remains PASS.
REQ-024 Check reset mid-operation: after input 1,0 (state INV), drive r=0 for one edge, then input 0,1,1 -> y=0,1,0. Also confirm y=0 while r=0.
REQ-025 Check simultaneous reset and 1: r=0 with i=1 at an edge -> state stays PASS. Then r=1 with i=0 -> y=0.
REQ-026 Check framing with INVERT_WORD_FRAME_EN and WORD_W=4: i = 1,1,1,1, 0,1,0,0 -> y = 1,0,0,0, 0,1,1,1. Without the macro, the same input -> y = 1,0,0,0, 1,0,1,1.
REQ-027 Check the alternating pattern from reset: i = 1,0,1,0 -> y = 1,1,0,1.
